qsq_operand_pipe: RTL and testbench



---
 rtl/qsq_pkg.sv | 22 ++
 rtl/qsq_abs_unit.sv | 28 ++
 rtl/qsq_operand_pipe.sv | 117 +++++++++++
 tb/tb_qsq_operand_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsq_pkg.sv
// rtl/qsq_pkg.sv - shared index-width/lane helpers and stage payload type for qsq_operand_pipe
`ifndef QSQ_PKG_SV
`define QSQ_PKG_SV

// Per-lane stage payload; a macro so the field widths follow the instantiating module's WIDTH.
`define QSQ_PAYLOAD_T(W) struct packed { logic [(W)-1:0] mag_a; logic [(W)-1:0] mag_b; logic sign; logic sat; }

package qsq_pkg;

    localparam int QSQ_IDX_EXTRA = 1;

    function automatic int idx_width(input int width);
        return width + QSQ_IDX_EXTRA;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`endif

// File: rtl/qsq_abs_unit.sv
// rtl/qsq_abs_unit.sv - per-operand magnitude, zero detect and optional min saturation (QSQ_SAT_MIN_EN)
module qsq_abs_unit #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag,
    output logic             zero,
    output logic             sat
);

    logic [WIDTH-1:0] neg;

    // The most-negative input negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign neg  = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    assign zero = (x == '0);

`ifdef QSQ_SAT_MIN_EN
    logic is_min;

    assign is_min = x[WIDTH-1] & ~|x[WIDTH-2:0];
    assign sat    = is_min;
    assign mag    = is_min ? {1'b0, {(WIDTH-1){1'b1}}} : (x[WIDTH-1] ? neg : x);
`else
    assign sat = 1'b0;
    assign mag = x[WIDTH-1] ? neg : x;
`endif

endmodule

// File: rtl/qsq_operand_pipe.sv
// rtl/qsq_operand_pipe.sv - two-stage quarter-square operand front-end; QSQ_SAT_MIN_EN enables min-value saturation
module qsq_operand_pipe
    import qsq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NCH   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NCH*WIDTH-1:0]                in_a,
    input  logic [NCH*WIDTH-1:0]                in_b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NCH*WIDTH-1:0]                out_mag_a,
    output logic [NCH*WIDTH-1:0]                out_mag_b,
    output logic [NCH-1:0]                      out_sign,
    output logic [NCH*idx_width(WIDTH)-1:0]     out_sum,
    output logic [NCH*WIDTH-1:0]                out_diff,
    output logic [NCH-1:0]                      out_sat
);

    localparam int IW = idx_width(WIDTH);

    typedef `QSQ_PAYLOAD_T(WIDTH) payload_t;

    logic s1_valid;
    logic s2_valid;
    logic s1_free;
    logic s2_free;
    logic accept;
    logic advance;

    assign s2_free   = !s2_valid || out_ready;
    assign s1_free   = !s1_valid || s2_free;
    assign in_ready  = s1_free;
    assign accept    = in_valid && in_ready;
    assign advance   = s1_valid && s2_free;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_free) s1_valid <= in_valid;
            if (s2_free) s2_valid <= s1_valid;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] abs_a;
        logic [WIDTH-1:0] abs_b;
        logic             zero_a;
        logic             zero_b;
        logic             sat_a;
        logic             sat_b;
        logic             sign;
        payload_t         s1_q;
        payload_t         s2_q;
        logic [IW-1:0]    s2_sum;
        logic [WIDTH-1:0] s2_diff;

        assign op_a = in_a[lane_lo(k, WIDTH) +: WIDTH];
        assign op_b = in_b[lane_lo(k, WIDTH) +: WIDTH];

        qsq_abs_unit #(.WIDTH(WIDTH)) u_abs_a (
            .x    (op_a),
            .mag  (abs_a),
            .zero (zero_a),
            .sat  (sat_a)
        );

        qsq_abs_unit #(.WIDTH(WIDTH)) u_abs_b (
            .x    (op_b),
            .mag  (abs_b),
            .zero (zero_b),
            .sat  (sat_b)
        );

        // A zero operand yields a zero product, which must not carry a negative sign.
        assign sign = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) && !zero_a && !zero_b;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q    <= '0;
                s2_q    <= '0;
                s2_sum  <= '0;
                s2_diff <= '0;
            end else begin
                if (accept) begin
                    s1_q.mag_a <= abs_a;
                    s1_q.mag_b <= abs_b;
                    s1_q.sign  <= sign;
                    s1_q.sat   <= sat_a || sat_b;
                end
                if (advance) begin
                    s2_q   <= s1_q;
                    s2_sum <= {1'b0, s1_q.mag_a} + {1'b0, s1_q.mag_b};
                    s2_diff <= (s1_q.mag_a >= s1_q.mag_b) ? (s1_q.mag_a - s1_q.mag_b)
                                                          : (s1_q.mag_b - s1_q.mag_a);
                end
            end
        end

        assign out_mag_a[lane_lo(k, WIDTH) +: WIDTH] = s2_q.mag_a;
        assign out_mag_b[lane_lo(k, WIDTH) +: WIDTH] = s2_q.mag_b;
        assign out_sign[k]                           = s2_q.sign;
        assign out_sat[k]                            = s2_q.sat;
        assign out_sum[lane_lo(k, IW) +: IW]         = s2_sum;
        assign out_diff[lane_lo(k, WIDTH) +: WIDTH]  = s2_diff;
    end

endmodule

// File: tb/tb_qsq_operand_pipe.sv
// tb/tb_qsq_operand_pipe.sv - directed bench with queue-based reference model for qsq_operand_pipe
module tb_qsq_operand_pipe;

    localparam int W  = 9;
    localparam int N  = 2;
    localparam int IW = W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_a;
    logic [N*W-1:0]   in_b;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_mag_a;
    logic [N*W-1:0]   out_mag_b;
    logic [N-1:0]     out_sign;
    logic [N*IW-1:0]  out_sum;
    logic [N*W-1:0]   out_diff;
    logic [N-1:0]     out_sat;

    always #5 clk = ~clk;

    qsq_operand_pipe #(.WIDTH(W), .NCH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag_a (out_mag_a),
        .out_mag_b (out_mag_b),
        .out_sign  (out_sign),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_sat   (out_sat)
    );

    typedef struct packed {
        int ma;
        int mb;
        bit sg;
        int sum;
        int diff;
        bit sat;
    } lane_exp_t;

    lane_exp_t exp_q [N][$];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_acc  = 0;
    int n_emit = 0;
    int n_drop = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: magnitudes, sign and LUT indices straight from integer arithmetic.
    function automatic lane_exp_t model(input int a, input int b);
        lane_exp_t e;
        int        amin;
        amin  = -(1 << (W - 1));
        e.sat = 1'b0;
        e.ma  = (a < 0) ? -a : a;
        e.mb  = (b < 0) ? -b : b;
`ifdef QSQ_SAT_MIN_EN
        if (a == amin) begin e.ma = (1 << (W - 1)) - 1; e.sat = 1'b1; end
        if (b == amin) begin e.mb = (1 << (W - 1)) - 1; e.sat = 1'b1; end
`else
        if (amin > 0) e.sat = 1'b1;
`endif
        e.sg   = ((a < 0) != (b < 0)) && (a != 0) && (b != 0);
        e.sum  = e.ma + e.mb;
        e.diff = (e.ma > e.mb) ? (e.ma - e.mb) : (e.mb - e.ma);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            n_drop += exp_q[0].size();
            for (int k = 0; k < N; k++) exp_q[k].delete();
        end else begin
            if (out_valid) begin
                if (exp_q[0].size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    for (int k = 0; k < N; k++) begin
                        lane_exp_t e;
                        e = exp_q[k][0];
                        chk($sformatf("lane%0d mag_a", k), out_mag_a[k*W +: W], e.ma);
                        chk($sformatf("lane%0d mag_b", k), out_mag_b[k*W +: W], e.mb);
                        chk($sformatf("lane%0d sign", k), out_sign[k], e.sg);
                        chk($sformatf("lane%0d sum", k), out_sum[k*IW +: IW], e.sum);
                        chk($sformatf("lane%0d diff", k), out_diff[k*W +: W], e.diff);
                        chk($sformatf("lane%0d sat", k), out_sat[k], e.sat);
                    end
                    if (out_ready) begin
                        for (int k = 0; k < N; k++) void'(exp_q[k].pop_front());
                        n_emit++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < N; k++) begin
                    int a;
                    int b;
                    a = int'($signed(in_a[k*W +: W]));
                    b = int'($signed(in_b[k*W +: W]));
                    exp_q[k].push_back(model(a, b));
                end
                n_acc++;
            end
        end
    end

    task automatic send(input int a0, input int b0, input int a1, input int b1);
        int guard;
        in_a[0*W +: W] = W'(a0);
        in_b[0*W +: W] = W'(b0);
        in_a[1*W +: W] = W'(a1);
        in_b[1*W +: W] = W'(b1);
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q[0].size() != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_queue_empty", exp_q[0].size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " in_ready"}, in_ready, 1);
        chk({tag, " data_zero"}, |{out_mag_a, out_mag_b, out_sign, out_sum, out_diff, out_sat}, 0);
    endtask

    int emit_before;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mixed signs per lane, checked against hand-computed literals and latency.
        send(-3, 5, 7, -7);
        chk("t1 latency_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        chk("t1 out_valid", out_valid, 1);
        chk("t1 l0 mag_a", out_mag_a[8:0], 3);
        chk("t1 l0 mag_b", out_mag_b[8:0], 5);
        chk("t1 l0 sum", out_sum[9:0], 8);
        chk("t1 l0 diff", out_diff[8:0], 2);
        chk("t1 l1 mag_a", out_mag_a[17:9], 7);
        chk("t1 l1 sum", out_sum[19:10], 14);
        chk("t1 l1 diff", out_diff[17:9], 0);
        chk("t1 sign", out_sign, 2'b11);
        drain();

        // Zero operand suppresses the sign.
        send(0, -100, -128, 127);
        @(posedge clk);
        #1;
        chk("t2 l0 sign", out_sign[0], 0);
        chk("t2 l0 mag_b", out_mag_b[8:0], 100);
        chk("t2 l0 sum", out_sum[9:0], 100);
        chk("t2 l0 diff", out_diff[8:0], 100);
        chk("t2 l1 sign", out_sign[1], 1);
        chk("t2 l1 diff", out_diff[17:9], 1);
        drain();

        // Most-negative operands.
        send(-256, -256, -256, 255);
        @(posedge clk);
        #1;
        chk("t3 l0 sign", out_sign[0], 0);
        chk("t3 l0 diff", out_diff[8:0], 0);
`ifdef QSQ_SAT_MIN_EN
        chk("t3 l0 mag_a", out_mag_a[8:0], 255);
        chk("t3 l0 sum", out_sum[9:0], 510);
        chk("t3 sat", out_sat, 2'b11);
`else
        chk("t3 l0 mag_a", out_mag_a[8:0], 256);
        chk("t3 l0 sum", out_sum[9:0], 512);
        chk("t3 l1 sum", out_sum[19:10], 511);
        chk("t3 sat", out_sat, 2'b00);
`endif
        drain();

        // Six-beat stream with a downstream stall.
        emit_before = n_emit;
        fork
            begin
                send(1, 2, -1, -2);
                send(-10, 20, 30, -40);
                send(100, 0, -50, -60);
                send(255, -255, 9, 9);
                send(-200, 13, 0, 0);
                send(42, -17, -99, 98);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("t4 in_ready_full", in_ready, 0);
                chk("t4 out_valid_stalled", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t4 six_emitted", n_emit - emit_before, 6);

        // Reset with two beats in flight.
        send(11, 12, 13, 14);
        send(-21, 22, 23, -24);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("t5 after_reset");
        send(-1, 2, 100, 50);
        chk("t5 latency_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        chk("t5 out_valid", out_valid, 1);
        chk("t5 l0 sum", out_sum[9:0], 3);
        chk("t5 l0 sign", out_sign[0], 1);
        chk("t5 l1 diff", out_diff[17:9], 50);
        chk("t5 l1 sum", out_sum[19:10], 150);
        drain();

        chk("accept_emit_balance", n_emit, n_acc - n_drop);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
